// File: rtl/mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// mod_counter_pkg
// Shared constants and constant functions for the modulo up/down counter.
//   clog2        : ceil(log2(value)), 0 for value <= 1
//   params_legal : elaboration-time legality of WIDTH / MODULUS / DIV
//   RST_COUNT    : count value loaded by reset
// No ports (package).
// -----------------------------------------------------------------------------
package mod_counter_pkg;

    localparam int RST_COUNT = 0;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic bit params_legal(input int width, input int modulus, input int div);
        longint span;
        span = longint'(1) << width;
        return (width >= 1) && (width <= 32) &&
               (modulus >= 2) && (longint'(modulus) <= span) &&
               (div >= 1) && (div <= 65535);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides enabled cycles by DIV and emits a one-cycle step request.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset, phase -> 0
//   en   : advances the phase; a frozen phase resumes where it stopped
//   clr  : restarts the phase at 0 (used by parallel load)
//   tick : step request, high on the enabled cycle the phase is at DIV-1
// -----------------------------------------------------------------------------
module tick_prescaler
    import mod_counter_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    if (DIV == 1) begin : g_bypass
        // Every enabled cycle is a step; no phase state exists.
        logic unused_inputs;
        assign unused_inputs = ^{clk, rst, clr};
        assign tick = en;
    end else begin : g_divide
        localparam int PW = clog2(DIV);
        localparam logic [PW-1:0] LAST = PW'(DIV - 1);

        logic [PW-1:0] phase_q;
        logic [PW-1:0] phase_d;

        always_comb begin
            phase_d = phase_q;
            if (clr) begin
                phase_d = '0;
            end else if (en) begin
                phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_d;
            end
        end

        assign tick = en && (phase_q == LAST);
    end

endmodule

// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
// Modulo-MODULUS up/down counter with parallel load, enable, prescaled step
// rate (DIV), terminal-count decode, wrap pulse and sticky ovf/unf flags.
// Optional feature macro: MOD_COUNTER_SATURATE_EN adds input 'sat'; when high
// the count holds at its end value instead of wrapping (flags still set).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   en         : count enable (gates prescaler and step)
//   up         : 1 = increment, 0 = decrement
//   load       : parallel load strobe (priority over step, ignores en)
//   load_val   : load value, clamped to MODULUS-1
//   clr_flags  : clears ovf/unf (a same-edge wrap wins)
//   sat        : saturate instead of wrap (only with MOD_COUNTER_SATURATE_EN)
//   count      : registered count, always in 0..MODULUS-1
//   tc         : terminal count decode of count and up
//   wrap       : registered pulse coincident with a wrapped count value
//   ovf, unf   : sticky up-wrap / down-wrap flags
// -----------------------------------------------------------------------------
module mod_updown_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int DIV     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
`ifdef MOD_COUNTER_SATURATE_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf,
    output logic             unf
);

    if (!params_legal(WIDTH, MODULUS, DIV)) begin : g_param_check
        $fatal(1, "mod_updown_counter: illegal WIDTH/MODULUS/DIV");
    end

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_COUNT);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             step;
    logic             hold_end;

`ifdef MOD_COUNTER_SATURATE_EN
    assign hold_end = sat;
`else
    assign hold_end = 1'b0;
`endif

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (step)
    );

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q & ~clr_flags;
        unf_d   = unf_q & ~clr_flags;
        if (load) begin
            // load_val < MODULUS is the same test as load_val <= MAX_C,
            // and stays within WIDTH bits even when MODULUS == 2**WIDTH.
            count_d = (load_val > MAX_C) ? MAX_C : load_val;
        end else if (step) begin
            if (up) begin
                if (count_q == MAX_C) begin
                    ovf_d = 1'b1;
                    if (!hold_end) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    unf_d = 1'b1;
                    if (!hold_end) begin
                        count_d = MAX_C;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST_C;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
    assign tc    = up ? (count_q == MAX_C) : (count_q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_updown_counter
// Directed bench for mod_updown_counter. Two instances share stimulus:
//   d1 : WIDTH=4, MODULUS=10, DIV=1
//   d3 : WIDTH=4, MODULUS=10, DIV=3
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, load, clr_flags;
    logic [3:0] load_val;
`ifdef MOD_COUNTER_SATURATE_EN
    logic       sat;
`endif
    logic [3:0] count1, count3;
    logic       tc1, wrap1, ovf1, unf1;
    logic       tc3, wrap3, ovf3, unf3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(1)) d1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flags(clr_flags),
`ifdef MOD_COUNTER_SATURATE_EN
        .sat(sat),
`endif
        .count(count1), .tc(tc1), .wrap(wrap1), .ovf(ovf1), .unf(unf1)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(3)) d3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flags(clr_flags),
`ifdef MOD_COUNTER_SATURATE_EN
        .sat(sat),
`endif
        .count(count3), .tc(tc3), .wrap(wrap3), .ovf(ovf3), .unf(unf3)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0; clr_flags = 1'b0;
`ifdef MOD_COUNTER_SATURATE_EN
        sat = 1'b0;
`endif
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count1 !== 4'd0) begin errors++; $display("FAIL reset_count1 got=%0d exp=0", count1); end
        checks++; if (count3 !== 4'd0) begin errors++; $display("FAIL reset_count3 got=%0d exp=0", count3); end
        checks++; if (wrap1 !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap1); end
        checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf1); end
        checks++; if (unf1 !== 1'b0) begin errors++; $display("FAIL reset_unf got=%b exp=0", unf1); end
        checks++; if (tc1 !== 1'b0) begin errors++; $display("FAIL reset_tc_up got=%b exp=0", tc1); end
        up = 1'b0;
        #1;
        checks++; if (tc1 !== 1'b1) begin errors++; $display("FAIL reset_tc_down got=%b exp=1", tc1); end
        up = 1'b1;
    endtask

    task automatic test_basic_up();
        logic [3:0] exp_c;
        do_reset();
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            cyc();
            exp_c = 4'(i % 10);
            checks++; if (count1 !== exp_c) begin errors++; $display("FAIL up_count[%0d] got=%0d exp=%0d", i, count1, exp_c); end
            checks++; if (wrap1 !== (i == 10)) begin errors++; $display("FAIL up_wrap[%0d] got=%b exp=%b", i, wrap1, (i == 10)); end
            checks++; if (ovf1 !== (i >= 10)) begin errors++; $display("FAIL up_ovf[%0d] got=%b exp=%b", i, ovf1, (i >= 10)); end
            checks++; if (tc1 !== (exp_c == 4'd9)) begin errors++; $display("FAIL up_tc[%0d] got=%b exp=%b", i, tc1, (exp_c == 4'd9)); end
        end
        checks++; if (unf1 !== 1'b0) begin errors++; $display("FAIL up_unf got=%b exp=0", unf1); end
    endtask

    task automatic test_down_wrap();
        logic [3:0] exp_seq [3];
        exp_seq = '{4'd1, 4'd0, 4'd9};
        do_reset();
        en = 1'b1; up = 1'b0; load = 1'b1; load_val = 4'd2;
        cyc();
        load = 1'b0;
        checks++; if (count1 !== 4'd2) begin errors++; $display("FAIL down_load got=%0d exp=2", count1); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (count1 !== exp_seq[i]) begin errors++; $display("FAIL down_count[%0d] got=%0d exp=%0d", i, count1, exp_seq[i]); end
            checks++; if (wrap1 !== (i == 2)) begin errors++; $display("FAIL down_wrap[%0d] got=%b exp=%b", i, wrap1, (i == 2)); end
            checks++; if (tc1 !== (exp_seq[i] == 4'd0)) begin errors++; $display("FAIL down_tc[%0d] got=%b exp=%b", i, tc1, (exp_seq[i] == 4'd0)); end
        end
        checks++; if (unf1 !== 1'b1) begin errors++; $display("FAIL down_unf got=%b exp=1", unf1); end
        checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL down_ovf got=%b exp=0", ovf1); end
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        checks++; if (count1 !== 4'd8) begin errors++; $display("FAIL clr_count got=%0d exp=8", count1); end
        checks++; if (unf1 !== 1'b0) begin errors++; $display("FAIL clr_unf got=%b exp=0", unf1); end
        repeat (8) cyc();
        checks++; if (count1 !== 4'd0) begin errors++; $display("FAIL down_to_zero got=%0d exp=0", count1); end
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        checks++; if (count1 !== 4'd9) begin errors++; $display("FAIL clr_wrap_count got=%0d exp=9", count1); end
        checks++; if (wrap1 !== 1'b1) begin errors++; $display("FAIL clr_wrap_pulse got=%b exp=1", wrap1); end
        checks++; if (unf1 !== 1'b1) begin errors++; $display("FAIL clr_vs_set_unf got=%b exp=1", unf1); end
    endtask

    task automatic test_prescaler();
        logic [3:0] exp_seq [7];
        exp_seq = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2};
        do_reset();
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc();
            checks++; if (count3 !== exp_seq[i]) begin errors++; $display("FAIL presc_count[%0d] got=%0d exp=%0d", i, count3, exp_seq[i]); end
        end
        en = 1'b0;
        cyc(); cyc();
        checks++; if (count3 !== 4'd2) begin errors++; $display("FAIL presc_frozen got=%0d exp=2", count3); end
        en = 1'b1;
        cyc();
        checks++; if (count3 !== 4'd2) begin errors++; $display("FAIL presc_resume got=%0d exp=2", count3); end
        cyc();
        checks++; if (count3 !== 4'd3) begin errors++; $display("FAIL presc_step got=%0d exp=3", count3); end
        checks++; if (wrap3 !== 1'b0) begin errors++; $display("FAIL presc_wrap got=%b exp=0", wrap3); end
    endtask

    task automatic test_load_clamp();
        do_reset();
        en = 1'b1; up = 1'b1;
        cyc();
        load = 1'b1; load_val = 4'd13;
        cyc();
        load = 1'b0;
        checks++; if (count1 !== 4'd9) begin errors++; $display("FAIL clamp_count1 got=%0d exp=9", count1); end
        checks++; if (wrap1 !== 1'b0) begin errors++; $display("FAIL clamp_wrap1 got=%b exp=0", wrap1); end
        checks++; if (count3 !== 4'd9) begin errors++; $display("FAIL clamp_count3 got=%0d exp=9", count3); end
        checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL clamp_ovf1 got=%b exp=0", ovf1); end
        cyc();
        checks++; if (count3 !== 4'd9) begin errors++; $display("FAIL restart_e1 got=%0d exp=9", count3); end
        checks++; if (wrap1 !== 1'b1) begin errors++; $display("FAIL after_clamp_wrap1 got=%b exp=1", wrap1); end
        cyc();
        checks++; if (count3 !== 4'd9) begin errors++; $display("FAIL restart_e2 got=%0d exp=9", count3); end
        cyc();
        checks++; if (count3 !== 4'd0) begin errors++; $display("FAIL restart_e3 got=%0d exp=0", count3); end
        checks++; if (wrap3 !== 1'b1) begin errors++; $display("FAIL restart_wrap3 got=%b exp=1", wrap3); end
        checks++; if (ovf3 !== 1'b1) begin errors++; $display("FAIL restart_ovf3 got=%b exp=1", ovf3); end
        en = 1'b0; load = 1'b1; load_val = 4'd5;
        cyc();
        load = 1'b0;
        checks++; if (count1 !== 4'd5) begin errors++; $display("FAIL load_no_en got=%0d exp=5", count1); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        en = 1'b1; up = 1'b1;
        repeat (22) cyc();
        checks++; if (count3 !== 4'd7) begin errors++; $display("FAIL midrun_pre got=%0d exp=7", count3); end
        checks++; if (ovf1 !== 1'b1) begin errors++; $display("FAIL midrun_pre_ovf1 got=%b exp=1", ovf1); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (count3 !== 4'd0) begin errors++; $display("FAIL midrun_count3 got=%0d exp=0", count3); end
        checks++; if (count1 !== 4'd0) begin errors++; $display("FAIL midrun_count1 got=%0d exp=0", count1); end
        checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL midrun_ovf1 got=%b exp=0", ovf1); end
        checks++; if (wrap1 !== 1'b0) begin errors++; $display("FAIL midrun_wrap1 got=%b exp=0", wrap1); end
        cyc(); cyc();
        checks++; if (count3 !== 4'd0) begin errors++; $display("FAIL midrun_hold got=%0d exp=0", count3); end
        cyc();
        checks++; if (count3 !== 4'd1) begin errors++; $display("FAIL midrun_first_step got=%0d exp=1", count3); end
    endtask

`ifdef MOD_COUNTER_SATURATE_EN
    task automatic test_saturate();
        do_reset();
        sat = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd8;
        cyc();
        load = 1'b0;
        checks++; if (count1 !== 4'd8) begin errors++; $display("FAIL sat_load got=%0d exp=8", count1); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (count1 !== 4'd9) begin errors++; $display("FAIL sat_count[%0d] got=%0d exp=9", i, count1); end
            checks++; if (wrap1 !== 1'b0) begin errors++; $display("FAIL sat_wrap[%0d] got=%b exp=0", i, wrap1); end
            checks++; if (ovf1 !== (i >= 1)) begin errors++; $display("FAIL sat_ovf[%0d] got=%b exp=%b", i, ovf1, (i >= 1)); end
        end
        sat = 1'b0; load = 1'b1; load_val = 4'd8;
        cyc();
        load = 1'b0;
        cyc();
        checks++; if (count1 !== 4'd9) begin errors++; $display("FAIL nosat_9 got=%0d exp=9", count1); end
        cyc();
        checks++; if (count1 !== 4'd0) begin errors++; $display("FAIL nosat_wrap_count got=%0d exp=0", count1); end
        checks++; if (wrap1 !== 1'b1) begin errors++; $display("FAIL nosat_wrap got=%b exp=1", wrap1); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_up();
        test_down_wrap();
        test_prescaler();
        test_load_clamp();
        test_reset_midrun();
`ifdef MOD_COUNTER_SATURATE_EN
        test_saturate();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
